encoder8x3_rr: RTL and testbench
================================

# encoder8x3_rr

Sequential 8-to-3 request encoder: the encode-side counterpart of the team's 3-to-8 decoder. It collects up to eight request lines into sticky pending flags and presents one pending index at a time as a 3-bit code with a valid/ready handshake. Selection is fixed-priority or round-robin. It sits between request sources and a consumer that acts on one binary index per transfer. A typical consumer is a 3x8 decoder that drives a one-hot grant.

## Interface
- RR, default 1: selection mode. 1 = round-robin starting at the rotating pointer; 0 = fixed priority, lowest index wins.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- in  input  8  request lines. A bit high for at least one cycle sets the matching pending flag.
- out  output  3  index being offered. Valid only while out_valid=1.
- out_valid  output  1  an index is offered.
- out_ready  input  1  consumer accepts the index this cycle.
- pend  output  8  current pending flags, registered.
- multi  output  1  more than one pending flag is set (popcount(pend) > 1).

## Operation
- State machine with two states, IDLE and OFFER. out_valid = (state == OFFER).
- Pending update on every clock when rst=0:
  - pend_next = (pend & ~clr) | in.
  - clr = onehot(out) when out_valid & out_ready, otherwise 0.
  - in has precedence: if a bit is popped and re-requested in the same cycle, the bit stays set.
- Selection function sel(v, ptr):
  - RR=0: lowest set bit of v.
  - RR=1: first set bit of v scanning ptr, ptr+1, … with modulo-8 wrap.
- Transitions:
  - IDLE: if pend_next != 0, latch out <= sel(pend_next, ptr) and move to OFFER. Otherwise stay in IDLE.
  - OFFER, out_ready=0: hold. out must not change, even if a higher-priority request arrives.
  - OFFER, out_ready=1: the transfer completes.
    - RR=1: ptr <= (out + 1) mod 8, 3-bit wrap, so 7 goes to 0.
    - If pend_next != 0: out <= sel(pend_next, ptr_after_pop) and stay in OFFER. This gives back-to-back transfers with no bubble.
    - Otherwise go to IDLE.
- When RR=0, ptr is held at 0 and never used.
- multi is computed from the pend register, not from pend_next.
- in is ignored while rst=1.

## Timing
- Reset values: pend=8'h00, out=3'b000, out_valid=0, multi=0, ptr=0, state=IDLE.
- Reset mid-operation: all pending requests and any in-flight offer are discarded with no transfer. out_valid=0 in the cycle after the reset edge.
- Latency, IDLE to first offer: in asserted in cycle N gives out_valid=1 and the correct out after edge N+1.
- Throughput: one transfer per cycle while out_ready=1 and requests remain pending.
- A transfer occurs on a rising edge where out_valid=1 and out_ready=1.
- out_ready while out_valid=0 has no effect.
- All outputs are driven directly from flops. There is no combinational path from in or out_ready to any output.
- Boundaries:
  - pend=8'hFF with RR=1 and ptr=7 offers 7 first, then wraps to 0.
  - A request on a bit that is currently being offered but not yet accepted merges into the existing flag. It is not counted twice.

## Test plan
- Reset: hold rst=1 for 2 cycles with in=8'hFF → out=000, out_valid=0, pend=00, multi=0. After release with in=0, the outputs stay idle.
- Single request (RR=0): in=8'b0000_0100 for one cycle, out_ready=1 → next cycle out=010, out_valid=1. One cycle later out_valid=0 and pend=00.
- Fixed-priority drain (RR=0): in=8'b1010_0010 for one cycle, out_ready held 1 → out=001, 101, 111 on consecutive cycles. multi=1 for the first two cycles, then 0. Then out_valid=0.
- Backpressure (RR=0): offer out=011 with out_ready=0, then pulse in[0] → out stays 011 for 5 stalled cycles. Raise out_ready → next out=000.
- Round-robin wrap (RR=1): after accepting index 5 (ptr=6), apply in=8'b0010_0001 → offers 000 first, then 101. Separately, in=8'hFF from ptr=0 → 000 through 111 in order, then ptr=0.
- Same-cycle pop and re-request: while index 3 is accepted, hold in[3]=1 → pend[3] stays 1 and index 3 is offered again. Then assert rst mid-drain → out_valid=0 and pend=00 after that edge.

Source files
------------

// File: rtl/encoder8x3_rr_if.sv
// Request/offer bundle between the 8-to-3 request encoder and its surroundings.
// master: the encoder, which offers indices. slave: the request sources and consumer.
interface encoder8x3_rr_if;
  logic [7:0] in;         // request lines
  logic       out_ready;  // consumer accepts the offered index
  logic [2:0] out;        // offered index
  logic       out_valid;  // an index is on offer
  logic [7:0] pend;       // sticky pending flags
  logic       multi;      // more than one flag pending

  modport master (
    input  in, out_ready,
    output out, out_valid, pend, multi
  );

  modport slave (
    output in, out_ready,
    input  out, out_valid, pend, multi
  );
endinterface

// File: rtl/encoder8x3_rr.sv
// Sequential 8-to-3 request encoder. Requests are collected into sticky
// pending flags and offered one binary index at a time over a valid/ready
// handshake. RR=1 selects round-robin from a rotating pointer, RR=0 selects
// fixed priority (lowest index wins). All outputs come straight from flops.
module encoder8x3_rr #(
  parameter bit RR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  encoder8x3_rr_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state_q;
  logic [7:0] pend_q;
  logic [7:0] pend_d;
  logic [7:0] clr;
  logic [2:0] out_q;
  logic [2:0] ptr_q;
  logic [2:0] ptr_d;
  logic       multi_q;
  logic       fire;

  // First set bit of v, scanning upward from ptr with modulo-8 wrap.
  // With ptr fixed at 0 this is plain lowest-index priority.
  function automatic logic [2:0] sel(input logic [7:0] v, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    sel   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && v[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  endfunction

  // A transfer happens on any edge where an index is offered and accepted.
  assign fire = (state_q == OFFER) && bus.out_ready;

  // Next pending flags and next pointer; a new request wins over a same-cycle pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    clr   = 8'h00;
    ptr_d = ptr_q;
    if (fire) begin
      clr = 8'h01 << out_q;
      if (RR) ptr_d = out_q + 3'd1;
    end
    pend_d = (pend_q & ~clr) | bus.in;
  end

  // Offer FSM with registered index, pending flags, pointer and multi flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 8'h00;
      out_q   <= 3'd0;
      ptr_q   <= 3'd0;
      multi_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      // multi tracks the pend register, so it is derived from the value pend_q takes now.
      multi_q <= |(pend_d & (pend_d - 8'd1));
      case (state_q)
        IDLE: begin
          if (pend_d != 8'h00) begin
            out_q   <= sel(pend_d, ptr_d);
            state_q <= OFFER;
          end
        end
        OFFER: begin
          // Without out_ready the offer is frozen, even against higher-priority arrivals.
          if (bus.out_ready) begin
            if (pend_d != 8'h00) begin
              out_q <= sel(pend_d, ptr_d);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = (state_q == OFFER);
  assign bus.pend      = pend_q;
  assign bus.multi     = multi_q;

endmodule

// File: tb/tb_encoder8x3_rr.sv
// Directed bench for encoder8x3_rr: one fixed-priority and one round-robin
// instance, driven from a table of per-cycle vectors plus a few sequences.
module tb_encoder8x3_rr;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  encoder8x3_rr_if if0 ();
  encoder8x3_rr_if if1 ();

  encoder8x3_rr #(.RR(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(if0.master));
  encoder8x3_rr #(.RR(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(if1.master));

  typedef struct {
    bit         rst;
    bit         dut;      // 0: fixed-priority instance, 1: round-robin instance
    logic [7:0] in;
    bit         rdy;
    bit         chk_out;
    logic [2:0] out;
    bit         valid;
    logic [7:0] pend;
    bit         multi;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(bit r, bit d, logic [7:0] i, bit y, bit c,
                              logic [2:0] o, bit v, logic [7:0] p, bit m);
    vec_t t;
    t.rst = r; t.dut = d; t.in = i; t.rdy = y; t.chk_out = c;
    t.out = o; t.valid = v; t.pend = p; t.multi = m;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit d, input logic [7:0] i, input bit y);
    if (d == 1'b0) begin
      if0.in = i;  if0.out_ready = y;
      if1.in = '0; if1.out_ready = 1'b0;
    end else begin
      if1.in = i;  if1.out_ready = y;
      if0.in = '0; if0.out_ready = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] o;
    logic       v;
    logic [7:0] p;
    logic       m;
    int         n;

    //   rst dut in     rdy chk out  v  pend   m
    // reset with requests held high, then idle with stray out_ready
    add(1, 0, 8'hFF, 0, 1, 3'd0, 0, 8'h00, 0);
    add(1, 0, 8'hFF, 0, 1, 3'd0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 1, 3'd0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 1, 1, 3'd0, 0, 8'h00, 0);
    // single request, one-cycle latency
    add(0, 0, 8'h04, 1, 1, 3'd2, 1, 8'h04, 0);
    add(0, 0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    // fixed-priority drain of 1010_0010
    add(0, 0, 8'hA2, 1, 1, 3'd1, 1, 8'hA2, 1);
    add(0, 0, 8'h00, 1, 1, 3'd5, 1, 8'hA0, 1);
    add(0, 0, 8'h00, 1, 1, 3'd7, 1, 8'h80, 0);
    add(0, 0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    // backpressure: offer 3 held for five stalled cycles despite in[0]
    add(0, 0, 8'h08, 0, 1, 3'd3, 1, 8'h08, 0);
    add(0, 0, 8'h01, 0, 1, 3'd3, 1, 8'h09, 1);
    add(0, 0, 8'h00, 0, 1, 3'd3, 1, 8'h09, 1);
    add(0, 0, 8'h00, 0, 1, 3'd3, 1, 8'h09, 1);
    add(0, 0, 8'h00, 0, 1, 3'd3, 1, 8'h09, 1);
    add(0, 0, 8'h00, 0, 1, 3'd3, 1, 8'h09, 1);
    add(0, 0, 8'h00, 1, 1, 3'd0, 1, 8'h01, 0);
    add(0, 0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    // re-request of the index on offer merges into the same flag
    add(0, 0, 8'h10, 0, 1, 3'd4, 1, 8'h10, 0);
    add(0, 0, 8'h10, 0, 1, 3'd4, 1, 8'h10, 0);
    add(0, 0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 3'd0, 0, 8'h00, 0);
    // same-cycle pop and re-request keeps the flag and re-offers it
    add(0, 0, 8'h08, 0, 1, 3'd3, 1, 8'h08, 0);
    add(0, 0, 8'h08, 1, 1, 3'd3, 1, 8'h08, 0);
    add(0, 0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    // reset mid-drain discards everything
    add(0, 0, 8'hE0, 1, 1, 3'd5, 1, 8'hE0, 1);
    add(0, 0, 8'h00, 1, 1, 3'd6, 1, 8'hC0, 1);
    add(1, 0, 8'h00, 1, 1, 3'd0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 1, 3'd0, 0, 8'h00, 0);
    // round-robin: 8'hFF from ptr 0 drains 0..7 in order
    add(0, 1, 8'hFF, 1, 1, 3'd0, 1, 8'hFF, 1);
    add(0, 1, 8'h00, 1, 1, 3'd1, 1, 8'hFE, 1);
    add(0, 1, 8'h00, 1, 1, 3'd2, 1, 8'hFC, 1);
    add(0, 1, 8'h00, 1, 1, 3'd3, 1, 8'hF8, 1);
    add(0, 1, 8'h00, 1, 1, 3'd4, 1, 8'hF0, 1);
    add(0, 1, 8'h00, 1, 1, 3'd5, 1, 8'hE0, 1);
    add(0, 1, 8'h00, 1, 1, 3'd6, 1, 8'hC0, 1);
    add(0, 1, 8'h00, 1, 1, 3'd7, 1, 8'h80, 0);
    add(0, 1, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    // pointer is back at 0: 1000_0001 offers 0 then 7, and 7 wraps ptr to 0
    add(0, 1, 8'h81, 0, 1, 3'd0, 1, 8'h81, 1);
    add(0, 1, 8'h00, 1, 1, 3'd7, 1, 8'h80, 0);
    add(0, 1, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    // accept 5 (ptr 6), then 0010_0001 offers 0 before 5
    add(0, 1, 8'h20, 1, 1, 3'd5, 1, 8'h20, 0);
    add(0, 1, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    add(0, 1, 8'h21, 0, 1, 3'd0, 1, 8'h21, 1);
    add(0, 1, 8'h00, 1, 1, 3'd5, 1, 8'h20, 0);
    add(0, 1, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    // accept 6 (ptr 7), then 8'hFF offers 7 first and wraps to 0
    add(0, 1, 8'h40, 1, 1, 3'd6, 1, 8'h40, 0);
    add(0, 1, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    add(0, 1, 8'hFF, 1, 1, 3'd7, 1, 8'hFF, 1);
    add(0, 1, 8'h00, 1, 1, 3'd0, 1, 8'h7F, 1);
    add(0, 1, 8'h00, 0, 1, 3'd0, 1, 8'h7F, 1);

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);

    foreach (vecs[k]) begin
      rst = vecs[k].rst;
      drive(vecs[k].dut, vecs[k].in, vecs[k].rdy);
      tick();
      if (vecs[k].dut == 1'b0) begin
        o = if0.out; v = if0.out_valid; p = if0.pend; m = if0.multi;
      end else begin
        o = if1.out; v = if1.out_valid; p = if1.pend; m = if1.multi;
      end
      check($sformatf("row%0d out_valid", k), {7'd0, v}, {7'd0, vecs[k].valid});
      check($sformatf("row%0d pend", k), p, vecs[k].pend);
      check($sformatf("row%0d multi", k), {7'd0, m}, {7'd0, vecs[k].multi});
      if (vecs[k].chk_out)
        check($sformatf("row%0d out", k), {5'd0, o}, {5'd0, vecs[k].out});
    end

    // Back-to-back round-robin drain of the remaining 0111_1111 (offer 0 pending).
    drive(1'b1, 8'h00, 1'b1);
    for (int i = 1; i < 7; i++) begin
      tick();
      check($sformatf("rr drain %0d out", i), {5'd0, if1.out}, 8'(i));
      check($sformatf("rr drain %0d valid", i), {7'd0, if1.out_valid}, 8'd1);
      check($sformatf("rr drain %0d pend", i), if1.pend, 8'h7F & ~((8'd1 << i) - 8'd1));
      check($sformatf("rr drain %0d multi", i), {7'd0, if1.multi}, {7'd0, (i < 6)});
    end
    tick();
    check("rr drain end valid", {7'd0, if1.out_valid}, 8'd0);
    check("rr drain end pend", if1.pend, 8'h00);

    // Reset, then a one-cycle request: offer must appear after exactly one edge.
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h40, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
      if0.in = 8'h00;
    end while (!if0.out_valid && n < 4);
    check("latency cycles", 8'(n), 8'd1);
    check("latency valid", {7'd0, if0.out_valid}, 8'd1);
    check("latency out", {5'd0, if0.out}, 8'd6);
    check("latency pend", if0.pend, 8'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
